fpu_round_pack: RTL and testbench

Registered rounding-and-packing stage that consumes the `fpu_result_t` produced by the FP multiply normalize stage. Applies the RISC-V rounding mode, handles mantissa carry-out, overflow and special values, and packs an IEEE-754 single-precision word with exception flags. It is a 2-deep valid/ready pipeline with a sticky accrued-flags register, sitting between normalize and FPU writeback.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_round_pkg.sv | 91 +++++++++
 rtl/fpu_round_pack_if.sv | 25 ++
 rtl/fpu_round_pipe_stage.sv | 45 ++++
 rtl/fpu_round_pack.sv | 103 ++++++++++
 tb/tb_fpu_round_pack.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: the normalize-stage result record and the rounding modes.
package fpu;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } fpu_round_mode_t;

  // Output of the multiply normalize stage; mantissa carries the hidden bit at [23].
  typedef struct packed {
    logic        sign;
    logic [23:0] mantissa;
    logic [7:0]  exponent;
    logic [2:0]  guard;     // {G,R,S}
    logic        nan;
    logic        inf;
    logic        zero;
    logic [2:0]  mode;      // raw encoding; 101-111 are treated as RNE
  } fpu_result_t;

endpackage

// File: rtl/fpu_round_pkg.sv
// Rounding/packing types, constants and the pure round/pack helper functions.
package fpu_round;
  import fpu::*;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_round_flags_t;

  localparam logic [31:0] CANONICAL_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FINITE_MAG = 32'h7F7F_FFFF;
  localparam logic [30:0] INF_MAG        = {8'hFF, 23'd0};

  // Special class resolved in S1 so S2 only has to select.
  typedef enum logic [2:0] {
    CLS_FINITE  = 3'd0,
    CLS_QNAN    = 3'd1,
    CLS_INVALID = 3'd2,
    CLS_INF     = 3'd3,
    CLS_ZERO    = 3'd4
  } fpu_round_class_t;

  // S1 payload: rounded and carry-adjusted mantissa/exponent plus context.
  typedef struct packed {
    logic             sign;
    logic [2:0]       mode;
    logic             inc;
    logic             nx;
    fpu_round_class_t cls;
    logic [24:0]      mant;
    logic [8:0]       exp;
  } fpu_round_s1_t;

  // S2 payload: final packed word and its exception flags.
  typedef struct packed {
    logic [31:0]      result;
    fpu_round_flags_t flags;
  } fpu_round_s2_t;

  function automatic logic fpu_round_increment(input logic       sign,
                                               input logic       lsb,
                                               input logic [2:0] guard,
                                               input logic [2:0] mode);
    logic any;
    any = |guard;
    case (mode)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign && any;
      RM_RUP:  return !sign && any;
      RM_RMM:  return guard[2];
      default: return guard[2] && (guard[1] || guard[0] || lsb);
    endcase
  endfunction

  function automatic fpu_round_s2_t fpu_round_pack(input fpu_round_s1_t s);
    fpu_round_s2_t r;
    logic          of;
    r  = '0;
    of = (s.exp >= 9'd255);
    case (s.cls)
      CLS_QNAN: r.result = CANONICAL_NAN;
      CLS_INVALID: begin
        r.result   = CANONICAL_NAN;
        r.flags.nv = 1'b1;
      end
      CLS_INF:  r.result = {s.sign, INF_MAG};
      CLS_ZERO: r.result = {s.sign, 31'd0};
      default: begin
        r.flags.of = of;
        r.flags.nx = s.nx || of;
        // Tininess is judged after rounding: exponent field still zero.
        r.flags.uf = r.flags.nx && !of && (s.exp == 9'd0);
        if (of) begin
          case (s.mode)
            RM_RTZ:  r.result = {s.sign, MAX_FINITE_MAG[30:0]};
            RM_RDN:  r.result = s.sign ? {1'b1, INF_MAG} : {1'b0, MAX_FINITE_MAG[30:0]};
            RM_RUP:  r.result = s.sign ? {1'b1, MAX_FINITE_MAG[30:0]} : {1'b0, INF_MAG};
            default: r.result = {s.sign, INF_MAG};
          endcase
        end else begin
          r.result = {s.sign, s.exp[7:0], s.mant[22:0]};
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fpu_round_pack_if.sv
// Upstream (normalize) and downstream (writeback) handshake bundle.
interface fpu_round_pack_if #(parameter int TAG_WIDTH = 5);
  import fpu::*;

  logic                 in_valid;
  logic                 in_ready;
  fpu_result_t          in_data;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_result;
  logic [4:0]           out_flags;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_tag
  );

endinterface

// File: rtl/fpu_round_pipe_stage.sv
// One valid/ready pipeline register; accepts whenever empty or being drained.
module fpu_round_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              advance;

  assign advance     = !valid_q || out_ready_i;
  assign in_ready_o  = advance;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next state: load on advance; payload held otherwise so outputs stay stable.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  // Stage register; reset clears payload too so the outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fpu_round_pack.sv
// Two-stage round-and-pack: S1 rounds the mantissa, S2 packs the IEEE word and flags.
module fpu_round_pack
  import fpu::*;
  import fpu_round::*;
#(
  parameter int TAG_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  fpu_round_pack_if.slave   bus,
  input  logic              flags_clear,
  output logic [4:0]        flags_sticky
);

  localparam int S1_W = $bits(fpu_round_s1_t) + TAG_WIDTH;
  localparam int S2_W = $bits(fpu_round_s2_t) + TAG_WIDTH;

  fpu_result_t          op;
  fpu_round_s1_t        s1_d, s1_q;
  fpu_round_s2_t        s2_d, s2_q;
  logic [TAG_WIDTH-1:0] s1_tag_q, s2_tag_q;
  logic [S1_W-1:0]      s1_out;
  logic [S2_W-1:0]      s2_out;
  logic                 s1_valid, s2_ready;
  logic                 inc;
  logic [24:0]          mant_r;
  logic [4:0]           sticky_q, sticky_d;

  assign op = bus.in_data;

  // S1 input: round increment, 25-bit rounded mantissa, carry and subnormal exponent fixups.
  always_comb begin
    inc     = fpu_round::fpu_round_increment(op.sign, op.mantissa[0], op.guard, op.mode);
    mant_r  = {1'b0, op.mantissa} + {24'd0, inc};
    s1_d    = '0;
    s1_d.sign = op.sign;
    s1_d.mode = op.mode;
    s1_d.inc  = inc;
    s1_d.nx   = |op.guard;
    if (mant_r[24]) begin
      s1_d.mant = mant_r >> 1;
      s1_d.exp  = {1'b0, op.exponent} + 9'd1;
    end else begin
      s1_d.mant = mant_r;
      s1_d.exp  = {1'b0, op.exponent};
    end
    if (op.exponent == 8'd0 && s1_d.mant[23]) s1_d.exp = 9'd1;
    if (op.nan)                 s1_d.cls = CLS_QNAN;
    else if (op.inf && op.zero) s1_d.cls = CLS_INVALID;
    else if (op.inf)            s1_d.cls = CLS_INF;
    else if (op.zero)           s1_d.cls = CLS_ZERO;
    else                        s1_d.cls = CLS_FINITE;
  end

  // ---- S1 register boundary ----
  fpu_round_pipe_stage #(.DATA_W(S1_W)) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .in_data_i  ({s1_d, bus.in_tag}),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_ready),
    .out_data_o (s1_out)
  );
  assign {s1_q, s1_tag_q} = s1_out;

  assign s2_d = fpu_round::fpu_round_pack(s1_q);

  // ---- S2 register boundary ----
  fpu_round_pipe_stage #(.DATA_W(S2_W)) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_ready),
    .in_data_i  ({s2_d, s1_tag_q}),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (s2_out)
  );
  assign {s2_q, s2_tag_q} = s2_out;

  assign bus.out_result = s2_q.result;
  assign bus.out_flags  = s2_q.flags;
  assign bus.out_tag    = s2_tag_q;
  assign flags_sticky   = sticky_q;

  // Sticky next state: a clear coinciding with a transfer keeps only that transfer's flags.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.out_valid && bus.out_ready)
      sticky_d = (flags_clear ? 5'd0 : sticky_q) | bus.out_flags;
    else if (flags_clear)
      sticky_d = 5'd0;
  end

  // Accrued exception flags register.
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 5'd0;
    else     sticky_q <= sticky_d;
  end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Scoreboard bench for fpu_round_pack: directed vectors, backpressure, reset and sticky flags.
module tb_fpu_round_pack;
  import fpu::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flags_clear;
  logic [4:0] flags_sticky;

  fpu_round_pack_if #(.TAG_WIDTH(5)) bus();

  fpu_round_pack #(.TAG_WIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flags_clear (flags_clear),
    .flags_sticky(flags_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;

  fpu_result_t vin  [13];
  logic [31:0] vres [13];
  logic [4:0]  vflg [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic fpu_result_t mk(input logic s, input logic [23:0] m, input logic [7:0] e,
                                     input logic [2:0] g, input logic n, input logic i,
                                     input logic z, input logic [2:0] md);
    fpu_result_t r;
    r.sign = s; r.mantissa = m; r.exponent = e; r.guard = g;
    r.nan = n; r.inf = i; r.zero = z; r.mode = md;
    return r;
  endfunction

  // Offer one operation; the expectation is queued at the cycle it is accepted.
  task automatic send(input fpu_result_t d, input logic [4:0] tag,
                      input logic [31:0] res, input logic [4:0] flg);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_tag   = tag;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout tag=%0d actual=not_accepted required=accepted", tag);
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back('{res, flg, tag});
      acc_cnt++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
  endtask

  // Monitor: every output handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", bus.out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.out_result, e.res);
        check("flags", {27'd0, bus.out_flags}, {27'd0, e.flg});
        check("tag", {27'd0, bus.out_tag}, {27'd0, e.tag});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vin[0]  = mk(0, 24'h800001, 8'h7F, 3'b100, 0, 0, 0, RM_RNE); vres[0]  = 32'h3F800002; vflg[0]  = 5'b00001;
    vin[1]  = mk(0, 24'h800000, 8'h7F, 3'b100, 0, 0, 0, RM_RNE); vres[1]  = 32'h3F800000; vflg[1]  = 5'b00001;
    vin[2]  = mk(0, 24'hFFFFFF, 8'h7F, 3'b100, 0, 0, 0, RM_RNE); vres[2]  = 32'h40000000; vflg[2]  = 5'b00001;
    vin[3]  = mk(1, 24'hFFFFFF, 8'hFE, 3'b111, 0, 0, 0, RM_RNE); vres[3]  = 32'hFF800000; vflg[3]  = 5'b00101;
    vin[4]  = mk(1, 24'hFFFFFF, 8'hFE, 3'b111, 0, 0, 0, RM_RTZ); vres[4]  = 32'hFF7FFFFF; vflg[4]  = 5'b00001;
    vin[5]  = mk(1, 24'hFFFFFF, 8'hFE, 3'b111, 0, 0, 0, RM_RDN); vres[5]  = 32'hFF800000; vflg[5]  = 5'b00101;
    vin[6]  = mk(1, 24'hFFFFFF, 8'hFE, 3'b111, 0, 0, 0, RM_RUP); vres[6]  = 32'hFF7FFFFF; vflg[6]  = 5'b00001;
    vin[7]  = mk(0, 24'h000000, 8'h00, 3'b000, 1, 0, 0, RM_RNE); vres[7]  = 32'h7FC00000; vflg[7]  = 5'b00000;
    vin[8]  = mk(0, 24'h000000, 8'h00, 3'b000, 0, 1, 1, RM_RNE); vres[8]  = 32'h7FC00000; vflg[8]  = 5'b10000;
    vin[9]  = mk(1, 24'h000000, 8'h00, 3'b000, 0, 0, 1, RM_RNE); vres[9]  = 32'h80000000; vflg[9]  = 5'b00000;
    vin[10] = mk(0, 24'h7FFFFF, 8'h00, 3'b100, 0, 0, 0, RM_RNE); vres[10] = 32'h00800000; vflg[10] = 5'b00001;
    vin[11] = mk(0, 24'h800001, 8'h7F, 3'b100, 0, 0, 0, 3'b111); vres[11] = 32'h3F800002; vflg[11] = 5'b00001;
    vin[12] = mk(1, 24'h000000, 8'h00, 3'b000, 0, 1, 0, RM_RNE); vres[12] = 32'hFF800000; vflg[12] = 5'b00000;

    rst = 1'b1; flags_clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_flags", {27'd0, bus.out_flags}, 32'd0);
    check("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
    check("rst_sticky", {27'd0, flags_sticky}, 32'd0);

    // Latency: out_valid absent one cycle after acceptance, present after two.
    send(vin[0], 5'd31, vres[0], vflg[0]);
    check("latency_c1", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("latency_c2", {31'd0, bus.out_valid}, 32'd1);
    wait_empty();

    // Directed vectors back to back.
    for (int i = 0; i < 13; i++) send(vin[i], 5'(i), vres[i], vflg[i]);
    wait_empty();
    check("sticky_all", {27'd0, flags_sticky}, {27'd0, 5'b10101});

    flags_clear = 1'b1;
    @(posedge clk);
    #1;
    flags_clear = 1'b0;
    check("sticky_clear_alone", {27'd0, flags_sticky}, 32'd0);

    // Backpressure: four offers against a stalled consumer.
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        send(vin[3], 5'd20, vres[3], vflg[3]);
        send(vin[0], 5'd21, vres[0], vflg[0]);
        send(vin[7], 5'd22, vres[7], vflg[7]);
        send(vin[8], 5'd23, vres[8], vflg[8]);
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    check("bp_accepted", acc_cnt, 32'd2);
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_out_tag_held", {27'd0, bus.out_tag}, 32'd20);
    check("bp_out_result_held", bus.out_result, 32'hFF800000);
    check("bp_sticky_stable", {27'd0, flags_sticky}, 32'd0);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 100 && acc_cnt < 4; n++) @(posedge clk);
    check("bp_all_accepted", acc_cnt, 32'd4);
    wait_empty();
    check("bp_sticky_after", {27'd0, flags_sticky}, {27'd0, 5'b10101});
    check("bp_drained_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send(vin[0], 5'd1, vres[0], vflg[0]);
    send(vin[1], 5'd2, vres[1], vflg[1]);
    @(posedge clk);
    #1;
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_sticky", {27'd0, flags_sticky}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_out_result", bus.out_result, 32'd0);
    bus.out_ready = 1'b1;

    // Clear coincident with an NX-only transfer keeps exactly that transfer's flags.
    send(vin[3], 5'd5, vres[3], vflg[3]);
    wait_empty();
    check("sticky_pre_clear", {27'd0, flags_sticky}, {27'd0, 5'b00101});
    send(vin[0], 5'd6, vres[0], vflg[0]);
    @(posedge clk);
    #1;
    check("coinc_out_valid", {31'd0, bus.out_valid}, 32'd1);
    flags_clear = 1'b1;
    @(posedge clk);
    #1;
    flags_clear = 1'b0;
    check("sticky_clear_coincident", {27'd0, flags_sticky}, {27'd0, 5'b00001});
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
